// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I/RV64I decode stage with a main + skid output buffer.
// Define RV_DECODE_M_EXT_EN to decode the M extension; otherwise those encodings are illegal.
module rv_decode_stage #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [3:0]           out_class,
  output logic [6:0]           out_kind,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [XLEN-1:0]      out_imm,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam bit IS64 = (XLEN == 64);

  typedef enum logic [3:0] {
    invalid, lui_type, auipc_type, jal_type, jalr_type, branch_type, load_type,
    store_type, reg_imm_type, reg_arith_type, fence_type, system_type
  } opcode_t;

  typedef enum logic [6:0] {
    LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, FENCE_I, ECALL, EBREAK, CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
    LWU, LD, SD, ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    MULW, DIVW, DIVUW, REMW, REMUW,
    ILLEGAL = 7'd127
  } instr_kind_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_C} fmt_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [6:0]      kind;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       shamt_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_c;

  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign shamt_ok = IS64 || !in_instr[25];

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign imm_c = XLEN'(in_instr[31:20]);

  opcode_t    cls;
  logic [6:0] kind;
  fmt_t       fmt;
  entry_t     dec;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    cls  = invalid;
    kind = ILLEGAL;
    fmt  = FMT_R;
    case (opc)
      7'b0110111: begin cls = lui_type;   kind = LUI;   fmt = FMT_U; end
      7'b0010111: begin cls = auipc_type; kind = AUIPC; fmt = FMT_U; end
      7'b1101111: begin cls = jal_type;   kind = JAL;   fmt = FMT_J; end
      7'b1100111: begin cls = jalr_type;  fmt = FMT_I; if (f3 == 3'b000) kind = JALR; end
      7'b1100011: begin
        cls = branch_type; fmt = FMT_B;
        case (f3)
          3'b000: kind = BEQ;  3'b001: kind = BNE;
          3'b100: kind = BLT;  3'b101: kind = BGE;
          3'b110: kind = BLTU; 3'b111: kind = BGEU;
          default: ;
        endcase
      end
      7'b0000011: begin
        cls = load_type; fmt = FMT_I;
        case (f3)
          3'b000: kind = LB;  3'b001: kind = LH;  3'b010: kind = LW;
          3'b100: kind = LBU; 3'b101: kind = LHU;
          3'b110: if (IS64) kind = LWU;
          3'b011: if (IS64) kind = LD;
          default: ;
        endcase
      end
      7'b0100011: begin
        cls = store_type; fmt = FMT_S;
        case (f3)
          3'b000: kind = SB; 3'b001: kind = SH; 3'b010: kind = SW;
          3'b011: if (IS64) kind = SD;
          default: ;
        endcase
      end
      7'b0010011: begin
        cls = reg_imm_type; fmt = FMT_I;
        case (f3)
          3'b000: kind = ADDI;  3'b010: kind = SLTI; 3'b011: kind = SLTIU;
          3'b100: kind = XORI;  3'b110: kind = ORI;  3'b111: kind = ANDI;
          3'b001: if (f7[6:1] == 6'b000000 && shamt_ok) kind = SLLI;
          3'b101: if (f7[6:1] == 6'b000000 && shamt_ok) kind = SRLI;
                  else if (f7[6:1] == 6'b010000 && shamt_ok) kind = SRAI;
          default: ;
        endcase
      end
      7'b0110011: begin
        cls = reg_arith_type; fmt = FMT_R;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: kind = ADD; 3'b001: kind = SLL; 3'b010: kind = SLT; 3'b011: kind = SLTU;
            3'b100: kind = XOR; 3'b101: kind = SRL; 3'b110: kind = OR;  3'b111: kind = AND;
            default: ;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000) kind = SUB;
          else if (f3 == 3'b101) kind = SRA;
`ifdef RV_DECODE_M_EXT_EN
        end else if (f7 == 7'b0000001) begin
          kind = 7'(MUL) + {4'b0, f3};  // MUL..REMU follow funct3 order
`endif
        end
      end
      7'b0011011: if (IS64) begin
        cls = reg_imm_type; fmt = FMT_I;
        if (f3 == 3'b000) kind = ADDIW;
        else if (f3 == 3'b001 && f7 == 7'b0000000) kind = SLLIW;
        else if (f3 == 3'b101 && f7 == 7'b0000000) kind = SRLIW;
        else if (f3 == 3'b101 && f7 == 7'b0100000) kind = SRAIW;
      end
      7'b0111011: if (IS64) begin
        cls = reg_arith_type; fmt = FMT_R;
        if (f7 == 7'b0000000) begin
          if (f3 == 3'b000) kind = ADDW;
          else if (f3 == 3'b001) kind = SLLW;
          else if (f3 == 3'b101) kind = SRLW;
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000) kind = SUBW;
          else if (f3 == 3'b101) kind = SRAW;
`ifdef RV_DECODE_M_EXT_EN
        end else if (f7 == 7'b0000001) begin
          case (f3)
            3'b000: kind = MULW;  3'b100: kind = DIVW; 3'b101: kind = DIVUW;
            3'b110: kind = REMW;  3'b111: kind = REMUW;
            default: ;
          endcase
`endif
        end
      end
      7'b0001111: begin
        cls = fence_type; fmt = FMT_I;
        if (f3 == 3'b000) kind = FENCE;
        else if (f3 == 3'b001) kind = FENCE_I;
      end
      7'b1110011: begin
        cls = system_type; fmt = (f3 == 3'b000) ? FMT_I : FMT_C;
        case (f3)
          3'b000: if (in_instr[19:7] == 13'd0 && in_instr[31:21] == 11'd0)
                    kind = in_instr[20] ? EBREAK : ECALL;
          3'b001: kind = CSRRW;  3'b010: kind = CSRRS;  3'b011: kind = CSRRC;
          3'b101: kind = CSRRWI; 3'b110: kind = CSRRSI; 3'b111: kind = CSRRCI;
          default: ;
        endcase
      end
      default: ;
    endcase

    dec    = '0;
    dec.pc = in_pc;
    if (kind == ILLEGAL) begin
      dec.kind    = ILLEGAL;
      dec.illegal = 1'b1;
    end else begin
      dec.cls  = cls;
      dec.kind = kind;
      // Register fields absent from the format stay zero.
      case (fmt)
        FMT_R: begin dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; end
        FMT_I: begin dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.imm = imm_i; end
        FMT_S: begin dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.imm = imm_s; end
        FMT_B: begin dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.imm = imm_b; end
        FMT_U: begin dec.rd = in_instr[11:7]; dec.imm = imm_u; end
        FMT_J: begin dec.rd = in_instr[11:7]; dec.imm = imm_j; end
        default: begin dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.imm = imm_c; end
      endcase
    end
  end

  entry_t               out_q, skid_q;
  logic                 out_valid_q, skid_valid_q;
  logic [ILL_CNT_W-1:0] ill_q;
  logic                 out_fire, in_fire;

  assign out_fire = out_valid_q & out_ready;
  assign in_fire  = in_valid & ~skid_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two data entries are reset as well, so every output reads 0 out of reset.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ill_q        <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: state uses <= so every branch below sees the pre-edge register values.
      if (out_fire && out_q.illegal && ill_q != '1) ill_q <= ill_q + 1'b1;
      if (out_fire || !out_valid_q) begin
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (in_fire) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (in_fire) begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_class   = out_q.cls;
  assign out_kind    = out_q.kind;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;
  assign ill_count   = ill_q;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode stage between fetch and issue.
- Accepts {pc, instr} over a valid/ready handshake and decodes opcode class, instruction kind, register indices and sign-extended immediate.
- Has a 2-entry (main + skid) output buffer, a flush input and a saturating illegal-instruction counter.
- Successor to the fixed RV32I enum set: generalised to XLEN 32/64, adds RV64 word ops and optional M-extension decode.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; 64 enables RV64I ops (LWU, LD, SD, *W forms, 6-bit shamt)
ILL_CNT_W, 16, width of illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all buffered and incoming instructions
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_pc  in  XLEN  instruction address
in_instr  in  32  raw instruction word
out_valid  out  1  decoded instruction available
out_ready  in  1  issue accepts
out_pc  out  XLEN  pc of decoded instruction
out_class  out  4  opcode class, ordinal of opcode_t (invalid=0 .. system_type=11)
out_kind  out  7  instruction kind, ordinal of instr_kind_t (LUI=0 .. CSRRCI=46); extensions below; 127 = illegal
out_rd, out_rs1, out_rs2  out  5 each  register indices, forced to 0 when the format lacks the field
out_imm  out  XLEN  sign-extended immediate; 0 for R-type
out_illegal  out  1  instruction illegal for this configuration
ill_count  out  ILL_CNT_W  saturating count of illegal instructions delivered

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid empty, in_ready=1, ill_count=0; all data outputs 0. Reset mid-transfer drops all instructions.
- Kind ordinals 47-58 (XLEN=64 only): LWU, LD, SD, ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW.
- Latency: accepted on edge N (in_valid&in_ready) -> out_valid at N+1 with decoded fields when the output register is empty or draining.
- Handshake:
  - out_* hold stable while out_valid&!out_ready.
  - in_ready = !skid_valid (registered, no combinational in->out path).
  - Accept while output stalled -> entry goes to skid.
  - Output transfer -> skid moves to output the same edge, else new input, else out_valid=0.
  - Strict FIFO order.
- Simultaneous accept + output transfer with skid empty: new entry loads output register directly; no bubble (full throughput).
- Flush: on an edge with flush=1, out_valid and skid_valid clear. Any input accepted that cycle is discarded and out_valid stays 0. in_ready is 1 on the next cycle. Flush beats all transfers.
- Decode:
  - Immediates per I/S/B/U/J format, sign-extended from the instruction MSB to XLEN. U-type = instr[31:12]<<12, sign-extended.
  - Shifts: XLEN=32 requires shamt[5]=0, else illegal. SLLIW/SRLIW/SRAIW require shamt[5]=0.
  - FENCE rd/rs1 reported as encoded.
  - ECALL/EBREAK need instr[19:7]=0.
  - CSR* imm = zero-extended csr address (instr[31:20]).
- Illegal: unknown opcode, funct3/funct7 combination, instr[1:0]!=2'b11, or an RV64 op when XLEN=32. Result: out_class=0, out_kind=127, out_illegal=1, rd/rs1/rs2/imm=0.
- ill_count increments on each output transfer with out_illegal=1; saturates at all-ones; flushed instructions are not counted.

Optional Feature:
RV_DECODE_M_EXT_EN
- Defined: OP/OP-32 with funct7=0000001 decode as reg_arith_type.
  - Kinds 59-66: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Kinds 67-71 (XLEN=64 only): MULW, DIVW, DIVUW, REMW, REMUW.
- Undefined: these encodings are illegal (kind 127, counted).

Test Plan:
- XLEN=32, in 0x00500093 (addi x1,x0,5), pc 0x100 -> next cycle out_valid=1, class=8, kind=18, rd=1, rs1=0, imm=5, pc=0x100.
- XLEN=64 in 0x43F0D093 (srai x1,x1,63) -> kind=26, imm[5:0]=63; same word with XLEN=32 -> out_illegal=1, kind=127, ill_count=1.
- Three back-to-back valids with out_ready=0 for 3 cycles -> in_ready low after 2nd accept; 3rd held by fetch. Release out_ready -> all three delivered in order, one per cycle, no bubble.
- in 0x00000000 then 0xFFFFFFFF -> both illegal, ill_count=2. With ILL_CNT_W=2, six illegals -> ill_count saturates at 3.
- Output stalled, skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, none of the three emerge, ill_count unchanged.
- With RV_DECODE_M_EXT_EN: 0x02B50533 (mul x10,x10,x11) -> kind=59, rd=10, rs1=10, rs2=11. Without the macro -> illegal.
